// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: start -> delay -> N pulses of runtime width/period.
// Optional define PULSE_TRAIN_RETRIGGER_EN lets start re-launch a train that is still busy.
module pulse_train_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [NUM_W-1:0] cfg_count,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulses_sent
);

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] width_q, width_nxt;
  logic [CNT_W-1:0] low_q, low_nxt;
  logic [NUM_W-1:0] count_q, count_nxt;
  logic [NUM_W-1:0] sent_nxt, sent_inc;
  logic [CNT_W-1:0] cfg_w_eff, cfg_low;
  logic [CNT_W:0]   cfg_diff;
  logic             can_start, accept, finish;
  logic             pulse_nxt, busy_nxt, done_nxt;

`ifdef PULSE_TRAIN_RETRIGGER_EN
  assign can_start = 1'b1;
`else
  assign can_start = (state == IDLE);
`endif

  assign accept    = start && !abort && can_start;
  assign cfg_w_eff = (cfg_width == '0) ? CNT_W'(1) : cfg_width;
  // Extra bit keeps P-W from wrapping when the period is shorter than the width.
  assign cfg_diff  = {1'b0, cfg_period} - {1'b0, cfg_w_eff};
  assign cfg_low   = (cfg_period <= cfg_w_eff) ? CNT_W'(1) : cfg_diff[CNT_W-1:0];
  assign sent_inc  = ((count_q == '0) && (pulses_sent == '1)) ? pulses_sent
                                                              : pulses_sent + NUM_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      width_q     <= '0;
      low_q       <= '0;
      count_q     <= '0;
      pulses_sent <= '0;
      pulse       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      width_q     <= width_nxt;
      low_q       <= low_nxt;
      count_q     <= count_nxt;
      pulses_sent <= sent_nxt;
      pulse       <= pulse_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    width_nxt = width_q;
    low_nxt   = low_q;
    count_nxt = count_q;
    sent_nxt  = pulses_sent;
    finish    = 1'b0;
    if ((state != IDLE) && abort) begin
      state_nxt = IDLE;
    end else if (accept) begin
      width_nxt = cfg_w_eff;
      low_nxt   = cfg_low;
      count_nxt = cfg_count;
      if (cfg_delay == '0) begin
        state_nxt = HIGH;
        timer_nxt = cfg_w_eff - CNT_W'(1);
        sent_nxt  = NUM_W'(1);
      end else begin
        state_nxt = DELAY;
        timer_nxt = cfg_delay - CNT_W'(1);
        sent_nxt  = '0;
      end
    end else begin
      case (state)
        DELAY, LOW: begin
          if (timer == '0) begin
            state_nxt = HIGH;
            timer_nxt = width_q - CNT_W'(1);
            sent_nxt  = sent_inc;
          end else begin
            timer_nxt = timer - CNT_W'(1);
          end
        end
        HIGH: begin
          if (timer != '0) begin
            timer_nxt = timer - CNT_W'(1);
          end else if ((count_q != '0) && (pulses_sent == count_q)) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end else begin
            state_nxt = LOW;
            timer_nxt = low_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pulse_nxt = (state_nxt == HIGH);
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = finish;
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed self-checking bench for pulse_train_gen; a second NUM_W=2 instance covers saturation.
// Honours PULSE_TRAIN_RETRIGGER_EN to pick the matching start-while-busy scenario.
module tb_pulse_train_gen;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, abort, start2, abort2;
  logic [15:0] cfg_delay, cfg_width, cfg_period;
  logic [7:0]  cfg_count;
  logic        pulse, busy, done, pulse2, busy2, done2;
  logic [7:0]  pulses_sent;
  logic [1:0]  pulses_sent2;
  int          vectors = 0;
  int          miscompares = 0;

  logic [1:16] t1_pulse, t1_busy, t1_done;
  logic [1:8]  t2_pulse, t2_busy, t2_done;
  logic [1:20] t3_pulse;
  logic [1:10] t6_pulse;
  int          t6_sent [1:10];

  always #5 clock = ~clock;

  pulse_train_gen #(.CNT_W(16), .NUM_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_period(cfg_period),
    .cfg_count(cfg_count), .pulse(pulse), .busy(busy), .done(done),
    .pulses_sent(pulses_sent)
  );

  pulse_train_gen #(.CNT_W(16), .NUM_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .abort(abort2),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_period(cfg_period),
    .cfg_count(cfg_count[1:0]), .pulse(pulse2), .busy(busy2), .done(done2),
    .pulses_sent(pulses_sent2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [15:0] w,
                               input logic [15:0] p, input logic [7:0] c,
                               input logic s, input logic a);
    cfg_delay  = d;
    cfg_width  = w;
    cfg_period = p;
    cfg_count  = c;
    start      = s;
    abort      = a;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    t1_pulse = 16'b0001100011000110;
    t1_busy  = 16'b1111111111111110;
    t1_done  = 16'b0000000000000001;
    t2_pulse = 8'b10101010;
    t2_busy  = 8'b11111110;
    t2_done  = 8'b00000001;
    t3_pulse = 20'b00111011101110111011;
    t6_pulse = 10'b1010101010;
    t6_sent  = '{1, 1, 2, 2, 3, 3, 3, 3, 3, 3};

    reset_n = 1'b0;
    start2  = 1'b0;
    abort2  = 1'b0;
    applyStimulus(16'd0, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset pulse", 32'(pulse), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset sent", 32'(pulses_sent), 32'd0);
    reset_n = 1'b1;
    tick();

    $display("[TB] test 1: D=3 W=2 P=5 C=3");
    applyStimulus(16'd3, 16'd2, 16'd5, 8'd3, 1'b1, 1'b0);
    tick();
    applyStimulus(16'd0, 16'd9, 16'd1, 8'd1, 1'b0, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick();
      checkOutput($sformatf("t1 pulse c%0d", c), 32'(pulse), 32'(t1_pulse[c]));
      checkOutput($sformatf("t1 busy c%0d", c), 32'(busy), 32'(t1_busy[c]));
      checkOutput($sformatf("t1 done c%0d", c), 32'(done), 32'(t1_done[c]));
    end
    checkOutput("t1 sent", 32'(pulses_sent), 32'd3);

    $display("[TB] test 2: D=0 W=0 P=1 C=4");
    applyStimulus(16'd0, 16'd0, 16'd1, 8'd4, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      checkOutput($sformatf("t2 pulse c%0d", c), 32'(pulse), 32'(t2_pulse[c]));
      checkOutput($sformatf("t2 busy c%0d", c), 32'(busy), 32'(t2_busy[c]));
      checkOutput($sformatf("t2 done c%0d", c), 32'(done), 32'(t2_done[c]));
    end
    checkOutput("t2 sent", 32'(pulses_sent), 32'd4);

    $display("[TB] test 3: D=2 W=3 P=4 C=0 with abort");
    applyStimulus(16'd2, 16'd3, 16'd4, 8'd0, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) tick();
      checkOutput($sformatf("t3 pulse c%0d", c), 32'(pulse), 32'(t3_pulse[c]));
      checkOutput($sformatf("t3 done c%0d", c), 32'(done), 32'd0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t3 abort pulse", 32'(pulse), 32'd0);
    checkOutput("t3 abort busy", 32'(busy), 32'd0);
    checkOutput("t3 abort done", 32'(done), 32'd0);
    checkOutput("t3 abort sent", 32'(pulses_sent), 32'd5);
    tick();
    checkOutput("t3 no late done", 32'(done), 32'd0);

    $display("[TB] test 4: start+abort in idle, reset mid-train");
    applyStimulus(16'd0, 16'd2, 16'd4, 8'd2, 1'b1, 1'b1);
    tick();
    applyStimulus(16'd0, 16'd2, 16'd4, 8'd2, 1'b0, 1'b0);
    checkOutput("t4 start+abort busy", 32'(busy), 32'd0);
    checkOutput("t4 start+abort sent", 32'(pulses_sent), 32'd5);
    applyStimulus(16'd1, 16'd4, 16'd8, 8'd2, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    tick();
    checkOutput("t4 high pulse", 32'(pulse), 32'd1);
    checkOutput("t4 high sent", 32'(pulses_sent), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t4 reset pulse", 32'(pulse), 32'd0);
    checkOutput("t4 reset busy", 32'(busy), 32'd0);
    checkOutput("t4 reset done", 32'(done), 32'd0);
    checkOutput("t4 reset sent", 32'(pulses_sent), 32'd0);
    reset_n = 1'b1;
    tick();
    checkOutput("t4 post-reset busy", 32'(busy), 32'd0);

`ifdef PULSE_TRAIN_RETRIGGER_EN
    $display("[TB] test 5: retrigger enabled");
    applyStimulus(16'd3, 16'd2, 16'd5, 8'd3, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) tick();
      checkOutput($sformatf("t5 pulse c%0d", c), 32'(pulse), 32'(t1_pulse[c]));
    end
    applyStimulus(16'd1, 16'd2, 16'd5, 8'd1, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    checkOutput("t5 retrig pulse", 32'(pulse), 32'd0);
    checkOutput("t5 retrig busy", 32'(busy), 32'd1);
    checkOutput("t5 retrig done", 32'(done), 32'd0);
    checkOutput("t5 retrig sent", 32'(pulses_sent), 32'd0);
    tick();
    checkOutput("t5 new high", 32'(pulse), 32'd1);
    checkOutput("t5 new sent", 32'(pulses_sent), 32'd1);
    tick();
    checkOutput("t5 new high2", 32'(pulse), 32'd1);
    tick();
    checkOutput("t5 new done", 32'(done), 32'd1);
    checkOutput("t5 new busy", 32'(busy), 32'd0);
`else
    $display("[TB] test 5: start while busy ignored");
    applyStimulus(16'd3, 16'd2, 16'd5, 8'd3, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick();
      if (c == 3) start = 1'b0;
      checkOutput($sformatf("t5 pulse c%0d", c), 32'(pulse), 32'(t1_pulse[c]));
      checkOutput($sformatf("t5 busy c%0d", c), 32'(busy), 32'(t1_busy[c]));
      checkOutput($sformatf("t5 done c%0d", c), 32'(done), 32'(t1_done[c]));
      if (c == 2) applyStimulus(16'd1, 16'd1, 16'd2, 8'd1, 1'b1, 1'b0);
    end
    checkOutput("t5 sent", 32'(pulses_sent), 32'd3);
`endif

    $display("[TB] test 6: NUM_W=2 saturation, cfg changes ignored");
    applyStimulus(16'd0, 16'd1, 16'd2, 8'd0, 1'b0, 1'b0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) tick();
      checkOutput($sformatf("t6 pulse c%0d", c), 32'(pulse2), 32'(t6_pulse[c]));
      checkOutput($sformatf("t6 sent c%0d", c), 32'(pulses_sent2), 32'(t6_sent[c]));
      if (c == 4) applyStimulus(16'd5, 16'd7, 16'd20, 8'd1, 1'b0, 1'b0);
    end
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    checkOutput("t6 abort busy", 32'(busy2), 32'd0);
    checkOutput("t6 abort done", 32'(done2), 32'd0);
    checkOutput("t6 abort sent", 32'(pulses_sent2), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
